// File: rtl/mouse_regs_pkg.sv
// Shared register-map constants, field offsets and per-axis position arithmetic
// for the PS/2 mouse register bank.
package mouse_regs_pkg;

    localparam int EVT_W = 21;

    localparam int A_POS_X   = 0;
    localparam int A_POS_Y   = 1;
    localparam int A_STATUS  = 2;
    localparam int A_SCALE_X = 3;
    localparam int A_SCALE_Y = 4;
    localparam int A_MIN_X   = 5;
    localparam int A_MAX_X   = 6;
    localparam int A_MIN_Y   = 7;
    localparam int A_MAX_Y   = 8;
    localparam int A_CTRL    = 9;
    localparam int A_EVENT   = 10;
    localparam int A_LEVEL   = 11;

    localparam int ST_BTN_LSB = 0;
    localparam int ST_XSIGN   = 3;
    localparam int ST_YSIGN   = 4;
    localparam int ST_NOACK   = 5;
    localparam int ST_OVF     = 6;
    localparam int ST_NEMPTY  = 7;

    localparam int CTRL_CLAMP = 0;
    localparam int CTRL_IRQ   = 1;

    localparam int EVT_DY_LSB  = 0;
    localparam int EVT_DX_LSB  = 9;
    localparam int EVT_BTN_LSB = 18;
    localparam int EVT_VALID   = 31;

    // Wide enough for a 32-bit position plus a 9-bit increment without overflow.
    localparam int ACC_W = 34;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t axis_next(input acc_t pos, input acc_t inc, input acc_t lo,
                                       input acc_t hi, input logic clamp_en, input int pos_w);
        acc_t sum;
        acc_t shl;
        int   sh;
        sum = pos + inc;
        sh  = ACC_W - pos_w;
        shl = sum <<< sh;
        if (clamp_en) begin
            if (lo > hi) begin
                return lo;
            end else if (sum < lo) begin
                return lo;
            end else if (sum > hi) begin
                return hi;
            end else begin
                return sum;
            end
        end else begin
            return shl >>> sh;
        end
    endfunction

endpackage

// File: rtl/mouse_event_fifo.sv
// Synchronous event FIFO; a pop in the same cycle frees the slot for a push when full.
module mouse_event_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_pop_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == {LW{1'b0}});
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    // Storage array; contents are only meaningful below the level count.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_reg_bank.sv
// CPU-visible register bank for the PS/2 mouse: position accumulation with clamp/wrap,
// readback scaling, packet event FIFO and level interrupt.
module ps2_mouse_reg_bank
    import mouse_regs_pkg::*;
#(
    parameter int POS_W      = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MDataReady,
    input  logic [2:0]        MBtn,
    input  logic [8:0]        MXInc,
    input  logic [8:0]        MYInc,
    input  logic              MErrNoAck,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              RdValid,
    output logic              ErrAddr,
    output logic              Irq
);

    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int VALID_BIT = (DATA_W > EVT_VALID) ? EVT_VALID : DATA_W - 1;
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};

    logic signed [POS_W-1:0] r_pos_x, r_pos_y, r_min_x, r_max_x, r_min_y, r_max_y;
    logic [5:0]        r_scale_x, r_scale_y, r_status_lo;
    logic [1:0]        r_ctrl;
    logic              r_ovf;
    acc_t              w_nx_acc, w_ny_acc;
    logic              w_addr_ok, w_wr_bad, w_rd_bad, w_wr_ok, w_pop, w_ovf_set;
    logic              w_wr_pos_x, w_wr_pos_y, w_full, w_empty, w_unused;
    logic [EVT_W-1:0]  w_fifo_dout;
    logic [LVL_W-1:0]  w_level;
    logic [DATA_W-1:0] w_rd_data;

    function automatic logic [DATA_W-1:0] sext(input logic signed [POS_W-1:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] scale_rd(input logic signed [POS_W-1:0] v,
                                                   input logic [5:0] sc);
        logic signed [DATA_W-1:0] ext;
        ext = DATA_W'(v);
        if (sc[5]) begin
            return ext >>> sc[4:0];
        end else begin
            return ext << sc[4:0];
        end
    endfunction

    assign w_addr_ok  = (Addr <= ADDR_W'(A_LEVEL));
    assign w_wr_bad   = WrEn & (~w_addr_ok | (Addr == ADDR_W'(A_EVENT)) | (Addr == ADDR_W'(A_LEVEL)));
    assign w_rd_bad   = RdEn & ~w_addr_ok;
    assign w_wr_ok    = WrEn & ~w_wr_bad;
    assign w_wr_pos_x = w_wr_ok & (Addr == ADDR_W'(A_POS_X));
    assign w_wr_pos_y = w_wr_ok & (Addr == ADDR_W'(A_POS_Y));
    assign w_pop      = RdEn & (Addr == ADDR_W'(A_EVENT));
    // A full FIFO only drops the packet when no pop frees a slot in the same cycle.
    assign w_ovf_set  = MDataReady & w_full & ~(w_pop & ~w_empty);
    assign w_nx_acc   = axis_next(ACC_W'(r_pos_x), ACC_W'($signed(MXInc)), ACC_W'(r_min_x),
                                  ACC_W'(r_max_x), r_ctrl[CTRL_CLAMP], POS_W);
    assign w_ny_acc   = axis_next(ACC_W'(r_pos_y), ACC_W'($signed(MYInc)), ACC_W'(r_min_y),
                                  ACC_W'(r_max_y), r_ctrl[CTRL_CLAMP], POS_W);
    assign w_unused   = ^{DataIn, w_nx_acc, w_ny_acc};

    mouse_event_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_push      (MDataReady),
        .i_push_data ({MBtn, MXInc, MYInc}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_dout),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    // Read data mux; out-of-map addresses and an empty EVENT read give zero.
    always_comb begin
        w_rd_data = {DATA_W{1'b0}};
        case (Addr)
            ADDR_W'(A_POS_X):   w_rd_data = scale_rd(r_pos_x, r_scale_x);
            ADDR_W'(A_POS_Y):   w_rd_data = scale_rd(r_pos_y, r_scale_y);
            ADDR_W'(A_STATUS):  w_rd_data = DATA_W'({~w_empty, r_ovf, r_status_lo});
            ADDR_W'(A_SCALE_X): w_rd_data = DATA_W'(r_scale_x);
            ADDR_W'(A_SCALE_Y): w_rd_data = DATA_W'(r_scale_y);
            ADDR_W'(A_MIN_X):   w_rd_data = sext(r_min_x);
            ADDR_W'(A_MAX_X):   w_rd_data = sext(r_max_x);
            ADDR_W'(A_MIN_Y):   w_rd_data = sext(r_min_y);
            ADDR_W'(A_MAX_Y):   w_rd_data = sext(r_max_y);
            ADDR_W'(A_CTRL):    w_rd_data = DATA_W'(r_ctrl);
            ADDR_W'(A_EVENT): begin
                if (!w_empty) begin
                    w_rd_data[EVT_W-1:0] = w_fifo_dout;
                    w_rd_data[VALID_BIT] = 1'b1;
                end else begin
                    w_rd_data = {DATA_W{1'b0}};
                end
            end
            ADDR_W'(A_LEVEL):   w_rd_data = DATA_W'(w_level);
            default:            w_rd_data = {DATA_W{1'b0}};
        endcase
    end

    // Configuration registers written by the CPU.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_scale_x <= 6'd0;
            r_scale_y <= 6'd0;
            r_min_x   <= POS_MIN;
            r_max_x   <= POS_MAX;
            r_min_y   <= POS_MIN;
            r_max_y   <= POS_MAX;
            r_ctrl    <= 2'd0;
        end else if (w_wr_ok) begin
            case (Addr)
                ADDR_W'(A_SCALE_X): r_scale_x <= DataIn[5:0];
                ADDR_W'(A_SCALE_Y): r_scale_y <= DataIn[5:0];
                ADDR_W'(A_MIN_X):   r_min_x   <= DataIn[POS_W-1:0];
                ADDR_W'(A_MAX_X):   r_max_x   <= DataIn[POS_W-1:0];
                ADDR_W'(A_MIN_Y):   r_min_y   <= DataIn[POS_W-1:0];
                ADDR_W'(A_MAX_Y):   r_max_y   <= DataIn[POS_W-1:0];
                ADDR_W'(A_CTRL):    r_ctrl    <= DataIn[1:0];
                default:            r_ctrl    <= r_ctrl;
            endcase
        end
    end

    // Position accumulators and packet status; a CPU write beats the packet increment.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pos_x     <= {POS_W{1'b0}};
            r_pos_y     <= {POS_W{1'b0}};
            r_status_lo <= 6'd0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr_pos_x)      r_pos_x <= DataIn[POS_W-1:0];
            else if (MDataReady) r_pos_x <= w_nx_acc[POS_W-1:0];
            if (w_wr_pos_y)      r_pos_y <= DataIn[POS_W-1:0];
            else if (MDataReady) r_pos_y <= w_ny_acc[POS_W-1:0];
            if (MDataReady)      r_status_lo <= {MErrNoAck, MYInc[8], MXInc[8], MBtn};
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_ok && (Addr == ADDR_W'(A_STATUS)) && DataIn[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Registered bus outputs and interrupt.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DataOut <= {DATA_W{1'b0}};
            RdValid <= 1'b0;
            ErrAddr <= 1'b0;
            Irq     <= 1'b0;
        end else begin
            RdValid <= RdEn;
            ErrAddr <= w_wr_bad | w_rd_bad;
            Irq     <= r_ctrl[CTRL_IRQ] & (~w_empty | r_ovf);
            if (RdEn) DataOut <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_reg_bank.sv
// Directed self-checking bench for ps2_mouse_reg_bank with default parameters.
module tb_ps2_mouse_reg_bank;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MDataReady = 1'b0;
    logic [2:0]  MBtn = 3'd0;
    logic [8:0]  MXInc = 9'd0;
    logic [8:0]  MYInc = 9'd0;
    logic        MErrNoAck = 1'b0;
    logic [7:0]  Addr = 8'd0;
    logic        WrEn = 1'b0;
    logic        RdEn = 1'b0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic        RdValid;
    logic        ErrAddr;
    logic        Irq;

    int n_vec  = 0;
    int n_miss = 0;

    ps2_mouse_reg_bank dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MDataReady (MDataReady),
        .MBtn       (MBtn),
        .MXInc      (MXInc),
        .MYInc      (MYInc),
        .MErrNoAck  (MErrNoAck),
        .Addr       (Addr),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .RdValid    (RdValid),
        .ErrAddr    (ErrAddr),
        .Irq        (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rdat, output logic rv, output logic err);
        @(negedge Clk);
        WrEn = wr; RdEn = rd; Addr = a; DataIn = wd;
        @(negedge Clk);
        rdat = DataOut; rv = RdValid; err = ErrAddr;
        WrEn = 1'b0; RdEn = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd_d;
        logic rv, err;
        bus(1'b1, 1'b0, a, d, rd_d, rv, err);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd_d;
        logic rv, err;
        bus(1'b0, 1'b1, a, 32'd0, rd_d, rv, err);
        check_val(tag, rd_d, exp);
        check_val({tag, "_rdvalid"}, {31'd0, rv}, 32'd1);
        check_val({tag, "_erraddr"}, {31'd0, err}, 32'd0);
    endtask

    task automatic pkt(input logic [2:0] b, input logic [8:0] dx, input logic [8:0] dy,
                       input logic noack);
        @(negedge Clk);
        MDataReady = 1'b1; MBtn = b; MXInc = dx; MYInc = dy; MErrNoAck = noack;
        @(negedge Clk);
        MDataReady = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    logic [31:0] exp_rst [12];
    logic [31:0] exp_evt [8];
    logic [31:0] rd_d;
    logic        rv, err;
    logic [2:0]  b;
    logic [8:0]  dx, dy;

    initial begin
        #1;
        check_val("rst_dataout", DataOut, 32'd0);
        check_val("rst_rdvalid", {31'd0, RdValid}, 32'd0);
        check_val("rst_erraddr", {31'd0, ErrAddr}, 32'd0);
        check_val("rst_irq", {31'd0, Irq}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Reset values of the whole map.
        for (int i = 0; i < 12; i++) exp_rst[i] = 32'd0;
        exp_rst[5] = 32'hFFFF_8000; exp_rst[6] = 32'h0000_7FFF;
        exp_rst[7] = 32'hFFFF_8000; exp_rst[8] = 32'h0000_7FFF;
        for (int i = 0; i < 12; i++) rd_chk($sformatf("rst_reg%0d", i), 8'(i), exp_rst[i]);

        // Accumulation and readback scaling.
        pkt(3'b101, 9'd5, 9'd0, 1'b0);
        pkt(3'b000, 9'h1FD, 9'd0, 1'b0);
        pkt(3'b010, 9'd0, 9'h100, 1'b1);
        rd_chk("pos_x_acc", 8'h00, 32'h0000_0002);
        rd_chk("pos_y_acc", 8'h01, 32'hFFFF_FF00);
        rd_chk("status_pkt", 8'h02, 32'h0000_00B2);
        rd_chk("level3", 8'h0B, 32'd3);
        wr(8'h03, 32'h21);
        rd_chk("pos_x_shr1", 8'h00, 32'd1);
        wr(8'h03, 32'h02);
        rd_chk("pos_x_shl2", 8'h00, 32'd8);
        wr(8'h04, 32'h24);
        rd_chk("pos_y_shr4", 8'h01, 32'hFFFF_FFF0);
        wr(8'h03, 32'h00);
        wr(8'h04, 32'h00);

        // Clamping, inverted bounds and wrap.
        wr(8'h09, 32'h1);
        wr(8'h06, 32'd10);
        wr(8'h00, 32'd8);
        pkt(3'b000, 9'd100, 9'd0, 1'b0);
        rd_chk("clamp_max", 8'h00, 32'd10);
        wr(8'h07, 32'd5);
        wr(8'h08, 32'd3);
        pkt(3'b000, 9'd0, 9'd1, 1'b0);
        rd_chk("clamp_min_gt_max", 8'h01, 32'd5);
        wr(8'h09, 32'h0);
        wr(8'h00, 32'h7FFF);
        pkt(3'b000, 9'd1, 9'd0, 1'b0);
        rd_chk("wrap_pos_x", 8'h00, 32'hFFFF_8000);
        wr(8'h09, 32'h1);
        wr(8'h05, 32'hFFFF_FFFB);
        rd_chk("min_x_sext", 8'h05, 32'hFFFF_FFFB);
        pkt(3'b000, 9'd0, 9'd0, 1'b0);
        rd_chk("clamp_lo", 8'h00, 32'hFFFF_FFFB);

        // Overflow, ordered drain and interrupt.
        do_reset();
        wr(8'h09, 32'h2);
        for (int i = 0; i < 9; i++) begin
            b  = 3'(i);
            dx = 9'(i + 1);
            dy = 9'(9'h1F0 + 9'(i));
            if (i < 8) exp_evt[i] = 32'h8000_0000 | {11'd0, b, dx, dy};
            pkt(b, dx, dy, 1'b0);
        end
        check_val("irq_full", {31'd0, Irq}, 32'd1);
        rd_chk("level_full", 8'h0B, 32'd8);
        rd_chk("status_ovf", 8'h02, 32'h0000_00D0);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("event%0d", i), 8'h0A, exp_evt[i]);
        rd_chk("event_empty", 8'h0A, 32'd0);
        rd_chk("level_empty", 8'h0B, 32'd0);
        check_val("irq_ovf_only", {31'd0, Irq}, 32'd1);
        wr(8'h02, 32'h40);
        @(negedge Clk);
        check_val("irq_cleared", {31'd0, Irq}, 32'd0);
        rd_chk("status_w1c", 8'h02, 32'h0000_0010);

        // CPU write to POS_X collides with a packet.
        @(negedge Clk);
        MDataReady = 1'b1; MBtn = 3'd0; MXInc = 9'd4; MYInc = 9'd0;
        WrEn = 1'b1; Addr = 8'h00; DataIn = 32'd100;
        @(negedge Clk);
        MDataReady = 1'b0; WrEn = 1'b0;
        rd_chk("pos_x_cpu_wins", 8'h00, 32'd100);
        rd_chk("pos_y_still_moves", 8'h01, 32'hFFFF_FF94);
        rd_chk("level_after_collide", 8'h0B, 32'd1);

        // Bad accesses.
        bus(1'b1, 1'b0, 8'h0A, 32'hFFFF_FFFF, rd_d, rv, err);
        check_val("wr_event_err", {31'd0, err}, 32'd1);
        check_val("wr_event_rv", {31'd0, rv}, 32'd0);
        bus(1'b0, 1'b1, 8'h0C, 32'd0, rd_d, rv, err);
        check_val("rd_0c_data", rd_d, 32'd0);
        check_val("rd_0c_rv", {31'd0, rv}, 32'd1);
        check_val("rd_0c_err", {31'd0, err}, 32'd1);
        bus(1'b1, 1'b0, 8'h20, 32'd55, rd_d, rv, err);
        check_val("wr_20_err", {31'd0, err}, 32'd1);
        rd_chk("pos_x_untouched", 8'h00, 32'd100);
        rd_chk("level_untouched", 8'h0B, 32'd1);

        // Reset landing between RdEn and the capturing edge.
        @(negedge Clk);
        Addr = 8'h00; RdEn = 1'b1;
        #2 Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_val("midrd_rdvalid", {31'd0, RdValid}, 32'd0);
        check_val("midrd_dataout", DataOut, 32'd0);
        RdEn = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_val("midrd_rdvalid_after", {31'd0, RdValid}, 32'd0);
        rd_chk("pos_x_after_reset", 8'h00, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
